// File: rtl/rx_buf_pkg.sv
// Shared types and constants for the receive character buffer.
// Defining RX_BUF_STORE_ERR_EN keeps erroneous characters, with the error bit as the entry MSB.
package rx_buf_pkg;

  localparam int DEPTH_DEFAULT     = 8;
  localparam int ADDR_W_DEFAULT    = 3;
  localparam int CHAR_W_DEFAULT    = 7;
  localparam int ERR_CNT_W_DEFAULT = 8;

`ifdef RX_BUF_STORE_ERR_EN
  localparam bit STORE_ERR_EN = 1'b1;
`else
  localparam bit STORE_ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } rx_state_e;

  function automatic int entry_width(input int char_w, input bit store_err);
    return store_err ? char_w + 1 : char_w;
  endfunction

endpackage

// File: rtl/rx_char_buffer_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and registered read port.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 7
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr_reg;
  logic [ADDR_W:0]  rd_ptr_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
  logic             do_write;
  logic             do_read;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                 (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // Both flags come from registered pointers, so a same-cycle pop never frees room for a push.
  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= do_read;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_read) begin
        rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/rx_char_buffer.sv
// Receiver-side character buffer: four-phase ack handshake into a FIFO, error counting, overflow flag.
// Build with RX_BUF_STORE_ERR_EN to store erroneous characters (error bit as entry MSB).
module rx_char_buffer
  import rx_buf_pkg::*;
#(
  parameter  int DEPTH     = DEPTH_DEFAULT,
  parameter  int ADDR_W    = ADDR_W_DEFAULT,
  parameter  int CHAR_W    = CHAR_W_DEFAULT,
  parameter  int ERR_CNT_W = ERR_CNT_W_DEFAULT,
  localparam int ENTRY_W   = entry_width(CHAR_W, STORE_ERR_EN)
) (
  input  logic                 clk_rx,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CHAR_W-1:0]    rx_character,
  input  logic                 rx_ready,
  input  logic                 rx_error,
  output logic                 rx_ack,
  input  logic                 rd_en,
  output logic [ENTRY_W-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_flags
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  rx_state_e            state_reg, state_next;
  logic [CHAR_W-1:0]    char_reg;
  logic                 err_reg;
  logic                 overflow_reg, overflow_next;
  logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;
  logic                 capture_load;
  logic                 err_event;
  logic                 store_char;
  logic                 fifo_wr;
  logic [ENTRY_W-1:0]   wr_data;

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_reg     <= IDLE;
      char_reg      <= '0;
      err_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      overflow_reg  <= overflow_next;
      err_count_reg <= err_count_next;
      if (capture_load) begin
        char_reg <= rx_character;
        err_reg  <= rx_error;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rx_ack       = 1'b0;
    capture_load = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && rx_ready) begin
          capture_load = 1'b1;
          state_next   = CAPTURE;
        end
      end
      CAPTURE: state_next = ACK;
      ACK: begin
        rx_ack = 1'b1;
        if (!rx_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign err_event  = (state_reg == CAPTURE) && err_reg;
  assign store_char = (state_reg == CAPTURE) && (!err_reg || STORE_ERR_EN);
  assign fifo_wr    = store_char && !full;

  // Clear is applied first so an event in the same cycle still lands (overflow=1, err_count=1).
  always_comb begin
    overflow_next  = clr_flags ? 1'b0 : overflow_reg;
    err_count_next = clr_flags ? '0 : err_count_reg;
    if (store_char && full) begin
      overflow_next = 1'b1;
    end
    if (err_event && (err_count_next != '1)) begin
      err_count_next = err_count_next + ERR_ONE;
    end
  end

  generate
    if (STORE_ERR_EN) begin : g_store_err
      assign wr_data = {err_reg, char_reg};
    end else begin : g_drop_err
      assign wr_data = char_reg;
    end
  endgenerate

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_fifo (
    .clk      (clk_rx),
    .srst     (rst),
    .wr_en    (fifo_wr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign overflow  = overflow_reg;
  assign err_count = err_count_reg;

endmodule
